// File: rtl/wgt_ctrl_pkg.sv
// Shared definitions for the double-buffered weight input controller.
// Holds the shadow-bank state encoding and the helper functions that
// derive lane count, slot count and index widths from the top parameters.
package wgt_ctrl_pkg;

    typedef enum logic [1:0] {
        WS_IDLE = 2'd0,
        WS_LOAD = 2'd1,
        WS_FULL = 2'd2
    } ws_state_t;

    // Weights carried by one FIFO word.
    function automatic int calc_epw(input int input_width, input int elem_width);
        return input_width / elem_width;
    endfunction

    // Slots in one weight bank (row-major, MAX_S slots per row).
    function automatic int calc_nslot(input int max_r, input int max_s);
        return max_r * max_s;
    endfunction

    // Index width that can address n entries (at least 1 bit).
    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo.sv
// First-word-fall-through FIFO.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   push        write wr_data (dropped when full)
//   wr_data     WIDTH-bit write word
//   pop         same-cycle read: advances past the head word (ignored when empty)
//   flush       empties the FIFO; a push in the same cycle is dropped
//   rd_data     head word, valid while ~empty
//   empty/full  status flags, decoded from the pointers
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: every output of this block is given a default first so no path leaves it unassigned, which would infer a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push && !full) begin
                mem_d[wr_ptr_q[AW-1:0]] = wr_data;
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array is not reset; only the pointers are, and a word is never read before it has been written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/wgt_bank.sv
// NSLOT x ELEM_WIDTH weight register bank, flattened slot-major (slot i at
// bits [i*ELEM_WIDTH +: ELEM_WIDTH]).
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clr         zero every slot (highest priority)
//   copy_en     load the whole bank from copy_data
//   wr_en       per-lane write enable (LANES lanes)
//   wr_slot     per-lane slot index, SLOT_W bits per lane
//   wr_data     per-lane weight, ELEM_WIDTH bits per lane
//   copy_data   full image of another bank
//   rd_data     current bank contents
module wgt_bank
    import wgt_ctrl_pkg::*;
#(
    parameter int ELEM_WIDTH = 8,
    parameter int NSLOT      = 25,
    parameter int LANES      = 4,
    parameter int SLOT_W     = calc_idx_w(NSLOT)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        copy_en,
    input  logic [LANES-1:0]            wr_en,
    input  logic [LANES*SLOT_W-1:0]     wr_slot,
    input  logic [LANES*ELEM_WIDTH-1:0] wr_data,
    input  logic [NSLOT*ELEM_WIDTH-1:0] copy_data,
    output logic [NSLOT*ELEM_WIDTH-1:0] rd_data
);

    logic [NSLOT*ELEM_WIDTH-1:0] slots_q, slots_d;

    assign rd_data = slots_q;

    always_comb begin
        slots_d = slots_q;
        if (clr) begin
            slots_d = '0;
        end else if (copy_en) begin
            slots_d = copy_data;
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (wr_en[k] && (int'(wr_slot[k*SLOT_W +: SLOT_W]) < NSLOT)) begin
                    slots_d[int'(wr_slot[k*SLOT_W +: SLOT_W])*ELEM_WIDTH +: ELEM_WIDTH] =
                        wr_data[k*ELEM_WIDTH +: ELEM_WIDTH];
                end
            end
        end
    end

    // Bank contents drive the MAC array directly, so they start from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots_q <= '0;
        end else begin
            slots_q <= slots_d;
        end
    end

endmodule

// File: rtl/weight_in_ctrl_db.sv
// Double-buffered weight input controller for the conv datapath.
// A FWFT FIFO (written from the AXI side) feeds a shadow bank; packed words are
// unpacked lane by lane into row-major slots. SWAP promotes the shadow filter
// to the active bank so the next filter can load while the current one is used.
// Ports:
//   CLK, RESETN              clock, async active-low reset
//   CLEAR, LOAD_REQ          register levels; each acts on its rising edge
//   SWAP                     promote shadow to active (only when shadow is full)
//   FIFO_WR_CMD/DATA         FIFO push (dropped when full)
//   PARAM_R/S                filter size, sampled when a load starts
//   FIFO_EMPTY/FULL          FIFO flags
//   LOADING, SHADOW_FULL     shadow FSM in LOAD / FULL
//   ACTIVE_VALID, ERR_PARAM  active filter present / sticky bad-size flag
//   ACT_R, ACT_S, ACT_DATA   active filter size and weights (slot r*MAX_S+c)
module weight_in_ctrl_db
    import wgt_ctrl_pkg::*;
#(
    parameter  int INPUT_WIDTH = 32,
    parameter  int ELEM_WIDTH  = 8,
    parameter  int FIFO_DEPTH  = 16,
    parameter  int MAX_R       = 5,
    parameter  int MAX_S       = 5,
    localparam int EPW         = calc_epw(INPUT_WIDTH, ELEM_WIDTH),
    localparam int NSLOT       = calc_nslot(MAX_R, MAX_S)
) (
    input  logic                        CLK,
    input  logic                        RESETN,
    input  logic                        CLEAR,
    input  logic                        LOAD_REQ,
    input  logic                        SWAP,
    input  logic                        FIFO_WR_CMD,
    input  logic [INPUT_WIDTH-1:0]      FIFO_WR_DATA,
    input  logic [3:0]                  PARAM_R,
    input  logic [3:0]                  PARAM_S,
    output logic                        FIFO_EMPTY,
    output logic                        FIFO_FULL,
    output logic                        LOADING,
    output logic                        SHADOW_FULL,
    output logic                        ACTIVE_VALID,
    output logic                        ERR_PARAM,
    output logic [3:0]                  ACT_R,
    output logic [3:0]                  ACT_S,
    output logic [NSLOT*ELEM_WIDTH-1:0] ACT_DATA
);

    localparam int SLOT_W = calc_idx_w(NSLOT);

    ws_state_t state_q, state_d;
    logic       clear_q, load_req_q;
    logic       clear_act, load_act;
    logic [3:0] r_lat_q, r_lat_d, s_lat_q, s_lat_d;
    logic [3:0] cnt_r_q, cnt_r_d, cnt_c_q, cnt_c_d;
    logic [3:0] act_r_q, act_r_d, act_s_q, act_s_d;
    logic       err_q, err_d;
    logic       act_valid_q, act_valid_d;

    logic                   fifo_pop, fifo_flush, fifo_empty, fifo_full;
    logic [INPUT_WIDTH-1:0] fifo_head;

    logic                        sh_clr, act_copy;
    logic [EPW-1:0]              sh_wr_en;
    logic [EPW-1:0]              lane_en;
    logic [EPW*SLOT_W-1:0]       lane_slot;
    logic [3:0]                  walk_r, walk_c;
    logic                        walk_done;
    logic                        params_ok;
    logic [NSLOT*ELEM_WIDTH-1:0] shadow_data;

    assign clear_act = CLEAR & ~clear_q;
    assign load_act  = LOAD_REQ & ~load_req_q;
    assign params_ok = (PARAM_R != 4'd0) && (int'(PARAM_R) <= MAX_R) &&
                       (PARAM_S != 4'd0) && (int'(PARAM_S) <= MAX_S);

    // Walk the lanes of the head word from (cnt_r, cnt_c). Once the row
    // counter reaches R every remaining lane is past the last element.
    always_comb begin : lane_walk
        logic [3:0] r;
        logic [3:0] c;
        r         = cnt_r_q;
        c         = cnt_c_q;
        lane_en   = '0;
        lane_slot = '0;
        for (int k = 0; k < EPW; k++) begin
            if (r < r_lat_q) begin
                lane_en[k] = 1'b1;
                lane_slot[k*SLOT_W +: SLOT_W] = SLOT_W'(int'(r) * MAX_S + int'(c));
                if (c == s_lat_q - 4'd1) begin
                    c = 4'd0;
                    r = r + 4'd1;
                end else begin
                    c = c + 4'd1;
                end
            end
        end
        walk_r    = r;
        walk_c    = c;
        walk_done = (r == r_lat_q);
    end

    always_comb begin
        state_d     = state_q;
        r_lat_d     = r_lat_q;
        s_lat_d     = s_lat_q;
        cnt_r_d     = cnt_r_q;
        cnt_c_d     = cnt_c_q;
        act_r_d     = act_r_q;
        act_s_d     = act_s_q;
        err_d       = err_q;
        act_valid_d = act_valid_q;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        sh_clr      = 1'b0;
        sh_wr_en    = '0;
        act_copy    = 1'b0;

        // CLEAR overrides any load request, swap or pop in the same cycle.
        if (clear_act) begin
            state_d    = WS_IDLE;
            fifo_flush = 1'b1;
            sh_clr     = 1'b1;
            err_d      = 1'b0;
        end else begin
            unique case (state_q)
                WS_IDLE: begin
                    if (load_act) begin
                        if (params_ok) begin
                            state_d = WS_LOAD;
                            r_lat_d = PARAM_R;
                            s_lat_d = PARAM_S;
                            cnt_r_d = 4'd0;
                            cnt_c_d = 4'd0;
                            sh_clr  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                WS_LOAD: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        sh_wr_en = lane_en;
                        cnt_r_d  = walk_r;
                        cnt_c_d  = walk_c;
                        if (walk_done) begin
                            state_d = WS_FULL;
                        end
                    end
                end
                WS_FULL: begin
                    if (SWAP) begin
                        state_d     = WS_IDLE;
                        act_copy    = 1'b1;
                        act_r_d     = r_lat_q;
                        act_s_d     = s_lat_q;
                        act_valid_d = 1'b1;
                    end
                end
                default: state_d = WS_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= WS_IDLE;
            clear_q     <= 1'b0;
            load_req_q  <= 1'b0;
            r_lat_q     <= '0;
            s_lat_q     <= '0;
            cnt_r_q     <= '0;
            cnt_c_q     <= '0;
            act_r_q     <= '0;
            act_s_q     <= '0;
            err_q       <= 1'b0;
            act_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_q     <= CLEAR;
            load_req_q  <= LOAD_REQ;
            r_lat_q     <= r_lat_d;
            s_lat_q     <= s_lat_d;
            cnt_r_q     <= cnt_r_d;
            cnt_c_q     <= cnt_c_d;
            act_r_q     <= act_r_d;
            act_s_q     <= act_s_d;
            err_q       <= err_d;
            act_valid_q <= act_valid_d;
        end
    end

    fifo #(
        .WIDTH (INPUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESETN),
        .push    (FIFO_WR_CMD),
        .wr_data (FIFO_WR_DATA),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    wgt_bank #(
        .ELEM_WIDTH (ELEM_WIDTH),
        .NSLOT      (NSLOT),
        .LANES      (EPW),
        .SLOT_W     (SLOT_W)
    ) u_shadow (
        .clk       (CLK),
        .rst_n     (RESETN),
        .clr       (sh_clr),
        .copy_en   (1'b0),
        .wr_en     (sh_wr_en),
        .wr_slot   (lane_slot),
        .wr_data   (fifo_head),
        .copy_data ('0),
        .rd_data   (shadow_data)
    );

    wgt_bank #(
        .ELEM_WIDTH (ELEM_WIDTH),
        .NSLOT      (NSLOT),
        .LANES      (EPW),
        .SLOT_W     (SLOT_W)
    ) u_active (
        .clk       (CLK),
        .rst_n     (RESETN),
        .clr       (1'b0),
        .copy_en   (act_copy),
        .wr_en     ('0),
        .wr_slot   ('0),
        .wr_data   ('0),
        .copy_data (shadow_data),
        .rd_data   (ACT_DATA)
    );

    assign FIFO_EMPTY   = fifo_empty;
    assign FIFO_FULL    = fifo_full;
    assign LOADING      = (state_q == WS_LOAD);
    assign SHADOW_FULL  = (state_q == WS_FULL);
    assign ACTIVE_VALID = act_valid_q;
    assign ERR_PARAM    = err_q;
    assign ACT_R        = act_r_q;
    assign ACT_S        = act_s_q;

endmodule

// File: tb/tb_weight_in_ctrl_db.sv
// Self-checking bench for weight_in_ctrl_db. Expected filters are pushed to a
// scoreboard when their words and load request are driven, and popped and
// compared against ACT_DATA/ACT_R/ACT_S when the swap is issued.
module tb_weight_in_ctrl_db;

    localparam int IW    = 32;
    localparam int EW    = 8;
    localparam int MAX_S = 5;
    localparam int NSLOT = 25;
    localparam int DW    = NSLOT * EW;

    logic          CLK;
    logic          RESETN;
    logic          CLEAR, LOAD_REQ, SWAP, FIFO_WR_CMD;
    logic [IW-1:0] FIFO_WR_DATA;
    logic [3:0]    PARAM_R, PARAM_S;
    logic          FIFO_EMPTY, FIFO_FULL, LOADING, SHADOW_FULL, ACTIVE_VALID, ERR_PARAM;
    logic [3:0]    ACT_R, ACT_S;
    logic [DW-1:0] ACT_DATA;

    weight_in_ctrl_db dut (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .CLEAR        (CLEAR),
        .LOAD_REQ     (LOAD_REQ),
        .SWAP         (SWAP),
        .FIFO_WR_CMD  (FIFO_WR_CMD),
        .FIFO_WR_DATA (FIFO_WR_DATA),
        .PARAM_R      (PARAM_R),
        .PARAM_S      (PARAM_S),
        .FIFO_EMPTY   (FIFO_EMPTY),
        .FIFO_FULL    (FIFO_FULL),
        .LOADING      (LOADING),
        .SHADOW_FULL  (SHADOW_FULL),
        .ACTIVE_VALID (ACTIVE_VALID),
        .ERR_PARAM    (ERR_PARAM),
        .ACT_R        (ACT_R),
        .ACT_S        (ACT_S),
        .ACT_DATA     (ACT_DATA)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [DW-1:0] data;
        logic [3:0]    r;
        logic [3:0]    s;
    } exp_t;

    exp_t          sb[$];
    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] last_act = '0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Word j of a filter: lane k carries element base + 4*j + k.
    function automatic logic [IW-1:0] mk_word(input int base, input int j);
        logic [IW-1:0] w;
        for (int k = 0; k < 4; k++) w[k*EW +: EW] = 8'((base + j*4 + k) & 255);
        return w;
    endfunction

    // Element e = base + e lands at row e/S, column e%S; everything else is 0.
    function automatic logic [DW-1:0] model(input int r, input int s, input int base);
        logic [DW-1:0] v;
        v = '0;
        for (int e = 0; e < r*s; e++) v[((e/s)*MAX_S + e%s)*EW +: EW] = 8'((base + e) & 255);
        return v;
    endfunction

    task automatic expect_filter(input int r, input int s, input int base);
        exp_t e;
        e.data = model(r, s, base);
        e.r    = 4'(r);
        e.s    = 4'(s);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_words(input int base, input int first, input int n);
        for (int j = first; j < first + n; j++) begin
            FIFO_WR_CMD  = 1'b1;
            FIFO_WR_DATA = mk_word(base, j);
            tick();
        end
        FIFO_WR_CMD = 1'b0;
    endtask

    task automatic pulse_load(input int r, input int s);
        PARAM_R  = 4'(r);
        PARAM_S  = 4'(s);
        LOAD_REQ = 1'b1;
        tick();
        LOAD_REQ = 1'b0;
    endtask

    task automatic pulse_clear();
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
    endtask

    task automatic wait_full(input string tag, input int budget);
        int n = 0;
        while (!SHADOW_FULL && n < budget) begin
            tick();
            n++;
        end
        check(tag, SHADOW_FULL, 1'b1);
    endtask

    task automatic compare_active(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1'b1, 1'b0);
        end else begin
            e = sb.pop_front();
            check({tag, "_data"}, ACT_DATA, e.data);
            check({tag, "_r"}, ACT_R, e.r);
            check({tag, "_s"}, ACT_S, e.s);
            check({tag, "_valid"}, ACTIVE_VALID, 1'b1);
            last_act = e.data;
        end
    endtask

    task automatic do_swap(input string tag);
        SWAP = 1'b1;
        tick();
        SWAP = 1'b0;
        check({tag, "_shadow_released"}, SHADOW_FULL, 1'b0);
        compare_active(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_cycles;
        int load_cycles;

        RESETN = 1'b0; CLEAR = 1'b0; LOAD_REQ = 1'b0; SWAP = 1'b0;
        FIFO_WR_CMD = 1'b0; FIFO_WR_DATA = '0; PARAM_R = '0; PARAM_S = '0;
        #2;
        check("rst_fifo_empty", FIFO_EMPTY, 1'b1);
        check("rst_flags", {FIFO_FULL, LOADING, SHADOW_FULL, ACTIVE_VALID, ERR_PARAM}, 5'b0);
        check("rst_act", {ACT_R, ACT_S, ACT_DATA}, '0);
        #10 RESETN = 1'b1;
        tick();

        // 1: 3x3 filter from three words; the last three lanes are dropped.
        push_words(0, 0, 3);
        expect_filter(3, 3, 0);
        pulse_load(3, 3);
        check("t1_loading", LOADING, 1'b1);
        tick();
        tick();
        check("t1_not_full_yet", {SHADOW_FULL, FIFO_EMPTY}, 2'b00);
        tick();
        check("t1_full_after_3rd", {SHADOW_FULL, FIFO_EMPTY, LOADING}, 3'b110);
        do_swap("t1");

        // 2: load B (5x5, 7 words) while A is active; SWAP during LOAD is ignored.
        push_words(8'h40, 0, 7);
        expect_filter(5, 5, 8'h40);
        pulse_load(5, 5);
        SWAP = 1'b1;
        tick();
        SWAP = 1'b0;
        check("t2_swap_in_load_ignored", LOADING, 1'b1);
        check("t2_act_held_a", ACT_DATA, last_act);
        wait_full("t2_full", 20);
        check("t2_act_still_a", ACT_DATA, last_act);
        do_swap("t2");

        // 3: underrun; R=2,S=3 needs two words and only one is present.
        push_words(8'h80, 0, 1);
        expect_filter(2, 3, 8'h80);
        pulse_load(2, 3);
        bad_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!LOADING || SHADOW_FULL) bad_cycles++;
        end
        check("t3_stall_cycles", bad_cycles, 0);
        push_words(8'h80, 1, 1);
        wait_full("t3_full", 5);
        do_swap("t3");

        // 4: bad parameters set the sticky error without popping.
        push_words(8'hA0, 0, 1);
        pulse_load(0, 3);
        check("t4_err_r0", {ERR_PARAM, LOADING}, 2'b10);
        tick(); tick(); tick();
        check("t4_no_pop", FIFO_EMPTY, 1'b0);
        pulse_clear();
        check("t4_clear_err", {ERR_PARAM, FIFO_EMPTY}, 2'b01);
        pulse_load(3, 6);
        check("t4_err_s6", {ERR_PARAM, LOADING}, 2'b10);
        pulse_clear();
        check("t4_clear_err2", ERR_PARAM, 1'b0);
        check("t4_active_kept", {ACTIVE_VALID, ACT_DATA}, {1'b1, last_act});

        // 5: CLEAR mid-load together with SWAP and a push.
        push_words(8'hC0, 0, 3);
        pulse_load(3, 3);
        tick();
        CLEAR = 1'b1; SWAP = 1'b1; FIFO_WR_CMD = 1'b1; FIFO_WR_DATA = mk_word(8'hF0, 0);
        tick();
        CLEAR = 1'b0; SWAP = 1'b0; FIFO_WR_CMD = 1'b0;
        check("t5_flags", {FIFO_EMPTY, LOADING, SHADOW_FULL, ERR_PARAM}, 4'b1000);
        check("t5_active_kept", {ACTIVE_VALID, ACT_DATA}, {1'b1, last_act});
        tick();
        check("t5_push_dropped", FIFO_EMPTY, 1'b1);

        // 6: LOAD_REQ held high -> one load; fill FIFO to 16 and try a 17th.
        PARAM_R = 4'd1; PARAM_S = 4'd1; LOAD_REQ = 1'b1;
        expect_filter(1, 1, 8'hD0);
        load_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            FIFO_WR_CMD  = (i == 0) || (i >= 20 && i <= 36);
            FIFO_WR_DATA = (i == 0) ? mk_word(8'hD0, 0) : mk_word(8'hE0, i - 20);
            SWAP         = (i == 10);
            tick();
            if (LOADING) load_cycles++;
            if (i == 35) check("t6_full_at_16", FIFO_FULL, 1'b1);
        end
        FIFO_WR_CMD = 1'b0; SWAP = 1'b0;
        check("t6_single_load", load_cycles, 1);
        check("t6_still_full", FIFO_FULL, 1'b1);
        compare_active("t6a");
        LOAD_REQ = 1'b0;
        tick();
        expect_filter(1, 1, 8'hE0);
        pulse_load(1, 1);
        wait_full("t6_full", 5);
        check("t6_pop_frees", FIFO_FULL, 1'b0);
        do_swap("t6b");

        pulse_load(5, 5);
        tick();
        check("t6_mid_load", LOADING, 1'b1);
        #3 RESETN = 1'b0;
        #1;
        check("t6_async_rst_empty", FIFO_EMPTY, 1'b1);
        check("t6_async_rst_flags", {FIFO_FULL, LOADING, SHADOW_FULL, ACTIVE_VALID, ERR_PARAM}, 5'b0);
        check("t6_async_rst_act", {ACT_R, ACT_S, ACT_DATA}, '0);
        #2 RESETN = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
